mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 84 ++++++++
 rtl/mult_div_unit.sv | 101 ++++++++++
 tb/tb_mult_div_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, default
// latencies, FSM states and the result arithmetic used by mult_div_unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic        div_zero;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_result_t;

    // Encodings 4-7 are reserved and never launch an operation.
    function automatic logic mdu_op_valid(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic mdu_result_t mdu_compute(input mdu_op_e     op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        mdu_result_t res;
        logic [63:0] prod;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        res   = '0;
        prod  = '0;
        a_mag = '0;
        b_mag = '0;
        q_mag = '0;
        r_mag = '0;
        case (op)
            MDU_MULT: begin
                // Low 64 bits of the sign-extended product equal the signed product.
                prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    res.div_zero = 1'b1;
                end else begin
                    // Magnitude divide keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
                    a_mag  = a[31] ? (~a + 32'd1) : a;
                    b_mag  = b[31] ? (~b + 32'd1) : b;
                    q_mag  = a_mag / b_mag;
                    r_mag  = a_mag % b_mag;
                    res.lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                    res.hi = a[31] ? (~r_mag + 32'd1) : r_mag;
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    res.div_zero = 1'b1;
                end else begin
                    res.lo = a / b;
                    res.hi = a % b;
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is staged from captured operands; latency comes from a down-counter.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic        HI_Write,
    input  logic        LO_Write,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e  state_reg,   state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [31:0] a_reg,       a_next;
    logic [31:0] b_reg,       b_next;
    mdu_op_e     op_reg,      op_next;
    mdu_result_t staging_reg, staging_next;
    logic [31:0] hi_reg,      hi_next;
    logic [31:0] lo_reg,      lo_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= MDU_MULT;
            staging_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            op_reg      <= op_next;
            staging_reg <= staging_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    // Staging is refreshed every busy cycle and consumed on the last one, so
    // both cycle counts are expected to be at least 2.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        op_next      = op_reg;
        staging_next = staging_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    if (mdu_op_valid(Op)) begin
                        a_next     = A;
                        b_next     = B;
                        op_next    = mdu_op_e'(Op);
                        count_next = Op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_next = ST_BUSY;
                    end
                end else begin
                    if (HI_Write) hi_next = A;
                    if (LO_Write) lo_next = A;
                end
            end
            ST_BUSY: begin
                staging_next = mdu_compute(op_reg, a_reg, b_reg);
                count_next   = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    if (!staging_reg.div_zero) begin
                        hi_next = staging_reg.hi;
                        lo_next = staging_reg.lo;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign Busy = (state_reg == ST_BUSY);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard of expected {HI,LO} pushed at
// Start and compared when Busy falls.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  Op;
    logic        HI_Write;
    logic        LO_Write;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int fails;
    logic [63:0] scoreboard[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op),
        .HI_Write(HI_Write), .LO_Write(LO_Write), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        longint sp;
        int sa;
        int sd;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return 64'(sp);
            end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {hi, lo};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                sa = int'(a);
                sd = int'(b);
                return {32'(sa % sd), 32'(sa / sd)};
            end
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] op);
        return (op < 3'd2) ? MC : DC;
    endfunction

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        if (op < 3'd4) begin
            e = model_op(op, a, b, model_hi, model_lo);
            scoreboard.push_back(e);
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] a);
        HI_Write = hw;
        LO_Write = lw;
        A        = a;
        if (hw) model_hi = a;
        if (lw) model_lo = a;
        @(posedge clk); #1;
        HI_Write = 1'b0;
        LO_Write = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", Busy); end
        checks++; if (HI !== 32'd0) begin fails++; $display("FAIL reset_hi got=%h want=0", HI); end
        checks++; if (LO !== 32'd0) begin fails++; $display("FAIL reset_lo got=%h want=0", LO); end
        $display("reset: busy=%b hi=%h lo=%h", Busy, HI, LO);
    endtask

    task automatic test_mult;
        int n;
        logic [63:0] e;
        logic [31:0] old_hi;
        old_hi = model_hi;
        launch(3'd0, 32'hFFFFFFFE, 32'd3);
        checks++; if (HI !== old_hi) begin fails++; $display("FAIL mult_hold_hi got=%h want=%h", HI, old_hi); end
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (n !== MC) begin fails++; $display("FAIL mult_cycles got=%0d want=%0d", n, MC); end
        checks++; if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFA) begin fails++; $display("FAIL mult_result got=%h want=FFFFFFFFFFFFFFFA", {HI, LO}); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL mult_scoreboard got=%h want=%h", {HI, LO}, e); end
        $display("mult a=fffffffe b=3 -> hi=%h lo=%h cycles=%0d", HI, LO, n);
        launch(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (n !== MC) begin fails++; $display("FAIL multu_cycles got=%0d want=%0d", n, MC); end
        checks++; if ({HI, LO} !== 64'h00000002_FFFFFFFA) begin fails++; $display("FAIL multu_result got=%h want=00000002FFFFFFFA", {HI, LO}); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL multu_scoreboard got=%h want=%h", {HI, LO}, e); end
        $display("multu a=fffffffe b=3 -> hi=%h lo=%h cycles=%0d", HI, LO, n);
    endtask

    task automatic test_div;
        int n;
        logic [63:0] e;
        launch(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (n !== DC) begin fails++; $display("FAIL div_cycles got=%0d want=%0d", n, DC); end
        checks++; if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL div_result got=%h want=FFFFFFFFFFFFFFFD", {HI, LO}); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL div_scoreboard got=%h want=%h", {HI, LO}, e); end
        $display("div a=fffffff9 b=2 -> hi=%h lo=%h cycles=%0d", HI, LO, n);
        launch(3'd3, 32'd7, 32'd2);
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if ({HI, LO} !== 64'h00000001_00000003) begin fails++; $display("FAIL divu_result got=%h want=0000000100000003", {HI, LO}); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL divu_scoreboard got=%h want=%h", {HI, LO}, e); end
        $display("divu a=7 b=2 -> hi=%h lo=%h cycles=%0d", HI, LO, n);
        launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if ({HI, LO} !== 64'h00000000_80000000) begin fails++; $display("FAIL div_overflow got=%h want=0000000080000000", {HI, LO}); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL div_overflow_sb got=%h want=%h", {HI, LO}, e); end
        $display("div a=80000000 b=ffffffff -> hi=%h lo=%h cycles=%0d", HI, LO, n);
    endtask

    task automatic test_div_zero;
        int n;
        logic [63:0] e;
        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
        checks++; if ({HI, LO} !== 64'h00000011_00000022) begin fails++; $display("FAIL mthi_mtlo got=%h want=0000001100000022", {HI, LO}); end
        launch(3'd3, 32'h1234, 32'd0);
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (n !== DC) begin fails++; $display("FAIL divzero_cycles got=%0d want=%0d", n, DC); end
        checks++; if ({HI, LO} !== 64'h00000011_00000022) begin fails++; $display("FAIL divzero_hold got=%h want=0000001100000022", {HI, LO}); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL divzero_scoreboard got=%h want=%h", {HI, LO}, e); end
        $display("divu a=1234 b=0 -> hi=%h lo=%h cycles=%0d", HI, LO, n);
    endtask

    task automatic test_hilo_write;
        int n;
        logic [63:0] e;
        write_hilo(1'b1, 1'b0, 32'hABCD0000);
        checks++; if (HI !== 32'hABCD0000) begin fails++; $display("FAIL mthi_idle got=%h want=ABCD0000", HI); end
        checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got=%b want=0", Busy); end
        write_hilo(1'b1, 1'b1, 32'h5A5A1234);
        checks++; if ({HI, LO} !== 64'h5A5A1234_5A5A1234) begin fails++; $display("FAIL mthi_mtlo_both got=%h want=5A5A12345A5A1234", {HI, LO}); end
        // Start together with a write: the operation wins
        HI_Write = 1'b1;
        launch(3'd1, 32'd3, 32'd4);
        HI_Write = 1'b0;
        checks++; if (Busy !== 1'b1) begin fails++; $display("FAIL start_wins_busy got=%b want=1", Busy); end
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if ({HI, LO} !== 64'h00000000_0000000C) begin fails++; $display("FAIL start_wins_result got=%h want=000000000000000C", {HI, LO}); end
        $display("multu+mthi a=3 b=4 -> hi=%h lo=%h cycles=%0d", HI, LO, n);
        // HI_Write in the third busy cycle of a mult
        launch(3'd0, 32'hFFFFFFFE, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        HI_Write = 1'b1;
        A = 32'hDEADBEEF;
        @(posedge clk); #1;
        HI_Write = 1'b0;
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (n !== MC - 3) begin fails++; $display("FAIL busy_write_cycles got=%0d want=%0d", n, MC - 3); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL busy_write_ignored got=%h want=%h", {HI, LO}, e); end
        $display("mult+busy mthi -> hi=%h lo=%h", HI, LO);
    endtask

    task automatic test_reset_busy;
        int n;
        logic [63:0] e;
        launch(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        e = scoreboard.pop_front();
        model_hi = '0;
        model_lo = '0;
        checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b want=0", Busy); end
        checks++; if ({HI, LO} !== 64'd0) begin fails++; $display("FAIL abort_hilo got=%h want=0", {HI, LO}); end
        $display("div aborted by reset -> busy=%b hi=%h lo=%h", Busy, HI, LO);
        launch(3'd3, 32'd7, 32'd2);
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (n !== DC) begin fails++; $display("FAIL post_reset_cycles got=%0d want=%0d", n, DC); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL post_reset_result got=%h want=%h", {HI, LO}, e); end
        $display("divu a=7 b=2 after reset -> hi=%h lo=%h cycles=%0d", HI, LO, n);
        // Reset and Start on the same edge
        Start = 1'b1; Op = 3'd0; A = 32'd2; B = 32'd2; reset = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_over_start got=%b want=0", Busy); end
        checks++; if ({HI, LO} !== 64'd0) begin fails++; $display("FAIL reset_over_start_hilo got=%h want=0", {HI, LO}); end
        $display("reset+start -> busy=%b hi=%h lo=%h", Busy, HI, LO);
    endtask

    task automatic test_reserved_and_hold;
        int n;
        logic [63:0] e;
        write_hilo(1'b1, 1'b1, 32'h77);
        launch(3'd5, 32'd9, 32'd9);
        checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL reserved_busy got=%b want=0", Busy); end
        @(posedge clk); #1;
        checks++; if ({HI, LO} !== 64'h00000077_00000077) begin fails++; $display("FAIL reserved_hilo got=%h want=0000007700000077", {HI, LO}); end
        $display("op=5 -> busy=%b hi=%h lo=%h", Busy, HI, LO);
        launch(3'd0, 32'd6, 32'd7);
        A = 32'h100;
        B = 32'h100;
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (LO !== 32'd42) begin fails++; $display("FAIL operand_hold got=%0d want=42", LO); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL operand_hold_sb got=%h want=%h", {HI, LO}, e); end
        $display("mult a=6 b=7 (A changed) -> hi=%h lo=%h cycles=%0d", HI, LO, n);
    endtask

    task automatic test_back_to_back;
        int n;
        logic [63:0] e;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        // A second Start during BUSY must not disturb the operation in flight
        launch(3'd1, 32'h10000, 32'h30000);
        Start = 1'b1; Op = 3'd3; A = 32'd1; B = 32'd0;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_done(n);
        e = scoreboard.pop_front();
        checks++; if (n !== MC - 1) begin fails++; $display("FAIL busy_start_cycles got=%0d want=%0d", n, MC - 1); end
        checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL busy_start_ignored got=%h want=%h", {HI, LO}, e); end
        $display("multu+busy start -> hi=%h lo=%h", HI, LO);
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (op >= 3'd2 && (i % 2) == 1) b = $urandom_range(1, 20);
            if (i == 4) b = 32'd0;
            launch(op, a, b);
            wait_done(n);
            e = scoreboard.pop_front();
            checks++; if (n !== exp_cycles(op)) begin fails++; $display("FAIL b2b_cycles[%0d] got=%0d want=%0d", i, n, exp_cycles(op)); end
            checks++; if ({HI, LO} !== e) begin fails++; $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, {HI, LO}, e); end
            $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", op, a, b, HI, LO, n);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        model_hi = '0;
        model_lo = '0;
        reset    = 1'b0;
        Start    = 1'b0;
        Op       = 3'd0;
        HI_Write = 1'b0;
        LO_Write = 1'b0;
        A        = '0;
        B        = '0;
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_hilo_write();
        test_reset_busy();
        test_reserved_and_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
